// File: rtl/axil_cmd_master.sv
// Single-outstanding AXI4-Lite initiator.
// Converts one command from a valid/ready command port into an AXI4-Lite
// write (AW+W then B) or read (AR then R) transaction, then presents the
// slave's response on a valid/ready response port.
//
// Handshake rule on every valid/ready pair in this block: a transfer happens
// on a rising clk edge where valid && ready are both high; a source never
// withdraws valid or changes its payload until that edge.
module axil_cmd_master #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    nrst,
  // command port
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
  // response port
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_write,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  // AXI write address channel
  output logic [ADDR_WIDTH-1:0]   awaddr,
  output logic [2:0]              awprot,
  output logic                    awvalid,
  input  logic                    awready,
  // AXI write data channel
  output logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH/8-1:0] wstrb,
  output logic                    wvalid,
  input  logic                    wready,
  // AXI write response channel
  input  logic [1:0]              bresp,
  input  logic                    bvalid,
  output logic                    bready,
  // AXI read address channel
  output logic [ADDR_WIDTH-1:0]   araddr,
  output logic [2:0]              arprot,
  output logic                    arvalid,
  input  logic                    arready,
  // AXI read data channel
  input  logic [DATA_WIDTH-1:0]   rdata,
  input  logic [1:0]              rresp,
  input  logic                    rvalid,
  output logic                    rready,
  // FSM state, for observation only
  output logic [2:0]              dbg_state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_DATA = 3'd4,
    RSP     = 3'd5
  } state_t;

  state_t state, state_nxt;

  // run_q keeps cmd_ready low while in reset and rises on the first edge after release
  logic run_q;
  logic aw_done, w_done;
  logic cmd_hs, aw_hs, w_hs, ar_hs, b_hs, r_hs;

  assign cmd_hs = cmd_valid && cmd_ready;
  assign aw_hs  = awvalid && awready;
  assign w_hs   = wvalid && wready;
  assign ar_hs  = arvalid && arready;
  assign b_hs   = bvalid && bready;
  assign r_hs   = rvalid && rready;

  assign cmd_ready = run_q && (state == IDLE);
  assign bready    = (state == WR_RESP);
  assign rready    = (state == RD_DATA);
  assign rsp_valid = (state == RSP);
  assign awprot    = 3'b000;
  assign arprot    = 3'b000;
  assign dbg_state = state;

  // State register
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode; an illegal encoding falls back to IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cmd_hs) state_nxt = cmd_write ? WR_REQ : RD_REQ;
      WR_REQ:  if ((aw_done || aw_hs) && (w_done || w_hs)) state_nxt = WR_RESP;
      WR_RESP: if (b_hs) state_nxt = RSP;
      RD_REQ:  if (ar_hs) state_nxt = RD_DATA;
      RD_DATA: if (r_hs) state_nxt = RSP;
      RSP:     if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Command latching, AXI request valids with per-channel done flags, response capture
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      run_q     <= 1'b0;
      awaddr    <= '0;
      wdata     <= '0;
      wstrb     <= '0;
      araddr    <= '0;
      awvalid   <= 1'b0;
      wvalid    <= 1'b0;
      arvalid   <= 1'b0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      rsp_write <= 1'b0;
      rsp_rdata <= '0;
      rsp_resp  <= 2'b00;
    end else begin
      run_q <= 1'b1;
      if (cmd_hs) begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
        if (cmd_write) begin
          awaddr  <= cmd_addr;
          wdata   <= cmd_wdata;
          wstrb   <= cmd_wstrb;
          awvalid <= 1'b1;
          wvalid  <= 1'b1;
        end else begin
          araddr  <= cmd_addr;
          arvalid <= 1'b1;
        end
      end
      if (aw_hs) begin
        awvalid <= 1'b0;
        aw_done <= 1'b1;
      end
      if (w_hs) begin
        wvalid <= 1'b0;
        w_done <= 1'b1;
      end
      if (ar_hs) arvalid <= 1'b0;
      if (b_hs) begin
        rsp_write <= 1'b1;
        rsp_resp  <= bresp;
        rsp_rdata <= '0;
      end
      if (r_hs) begin
        rsp_write <= 1'b0;
        rsp_resp  <= rresp;
        rsp_rdata <= rdata;
      end
    end
  end

endmodule

// File: tb/tb_axil_cmd_master.sv
// Bench for axil_cmd_master: a register-file AXI4-Lite slave model with
// programmable ready delays and response codes, a command driver, and a
// response monitor that pops a scoreboard queue of expected responses.
module tb_axil_cmd_master;

  localparam int AW = 3;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  // clock / reset
  logic clk = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [SW-1:0] cmd_wstrb;
  logic          rsp_valid, rsp_ready, rsp_write;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
  logic [AW-1:0] awaddr, araddr;
  logic [2:0]    awprot, arprot;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rvalid, rready;
  logic [DW-1:0] wdata, rdata;
  logic [SW-1:0] wstrb;
  logic [1:0]    bresp, rresp;
  logic [2:0]    dbg_state;

  axil_cmd_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .nrst(nrst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .dbg_state(dbg_state)
  );

  // scoreboard state
  logic [DW+2:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int rsp_count = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // slave model configuration
  int         aw_delay = 0;
  int         w_delay  = 0;
  logic [1:0] bresp_cfg = 2'b00;
  logic [1:0] rresp_cfg = 2'b00;

  logic [DW-1:0] mem [2];
  int            aw_cnt, w_cnt;
  logic          aw_got, w_got;
  logic [AW-1:0] wr_addr_q;
  logic [DW-1:0] wr_data_q;
  logic [SW-1:0] wr_strb_q;

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] d,
                                          input logic [SW-1:0] s);
    logic [DW-1:0] r;
    r = old;
    for (int b = 0; b < SW; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  assign awready = awvalid && (aw_cnt >= aw_delay);
  assign wready  = wvalid && (w_cnt >= w_delay);
  assign arready = arvalid;

  // slave model: ready delays counted while valid is high, B after AW and W, R one cycle after AR
  always @(posedge clk or negedge nrst) begin
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [SW-1:0] s;
    if (!nrst) begin
      aw_cnt <= 0; w_cnt <= 0; aw_got <= 1'b0; w_got <= 1'b0;
      bvalid <= 1'b0; bresp <= 2'b00; rvalid <= 1'b0; rresp <= 2'b00; rdata <= '0;
    end else begin
      if (awvalid && awready) begin aw_cnt <= 0; aw_got <= 1'b1; wr_addr_q <= awaddr; end
      else if (awvalid) aw_cnt <= aw_cnt + 1;
      if (wvalid && wready) begin w_cnt <= 0; w_got <= 1'b1; wr_data_q <= wdata; wr_strb_q <= wstrb; end
      else if (wvalid) w_cnt <= w_cnt + 1;
      if ((aw_got || (awvalid && awready)) && (w_got || (wvalid && wready)) && !bvalid) begin
        a = aw_got ? wr_addr_q : awaddr;
        d = w_got ? wr_data_q : wdata;
        s = w_got ? wr_strb_q : wstrb;
        mem[a[2]] <= merge(mem[a[2]], d, s);
        bvalid <= 1'b1; bresp <= bresp_cfg; aw_got <= 1'b0; w_got <= 1'b0;
      end else if (bvalid && bready) bvalid <= 1'b0;
      if (arvalid && arready) begin rvalid <= 1'b1; rdata <= mem[araddr[2]]; rresp <= rresp_cfg; end
      else if (rvalid && rready) rvalid <= 1'b0;
    end
  end

  // response monitor: a transfer completes on the next rising edge
  always @(negedge clk) begin
    if (nrst && rsp_valid && rsp_ready) begin
      rsp_count++;
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL rsp_unexpected: got 0x%0h expected none", {rsp_write, rsp_resp, rsp_rdata});
      end else begin
        check("rsp", {rsp_write, rsp_resp, rsp_rdata}, exp_q.pop_front());
      end
    end
  end

  // driver: issue one command, push its expected response; returns one cycle after acceptance
  task automatic send_cmd(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [SW-1:0] s, input logic [1:0] er, input logic [DW-1:0] ed);
    int n = 0;
    while (!cmd_ready && n < 100) begin @(posedge clk); #1; n++; end
    if (!cmd_ready) begin
      checks++; errors++;
      $display("FAIL cmd_ready_timeout: got 0 expected 1");
      return;
    end
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    exp_q.push_back({wr, er, wr ? {DW{1'b0}} : ed});
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin @(posedge clk); #1; n++; end
    check("rsp_drain", 64'(exp_q.size()), 0);
  endtask

  task automatic tick(); @(posedge clk); #1; endtask

  initial begin
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    rsp_ready = 1'b1;
    mem[0] = '0; mem[1] = '0;

    // reset values
    tick(); tick();
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_valids", {awvalid, wvalid, arvalid, bready, rready, rsp_valid}, 0);
    check("rst_rsp", {rsp_write, rsp_resp, rsp_rdata}, 0);
    check("rst_addr_data", {awaddr, araddr, wdata, wstrb, awprot, arprot}, 0);
    nrst = 1'b1;
    tick();
    check("cmd_ready_after_rst", cmd_ready, 1);

    // zero-wait write: AW and W same cycle, bready next cycle, response after
    send_cmd(1'b1, 3'd0, 32'h1234_5678, 4'hF, 2'b00, '0);
    check("t1_aw_w_hs", {awvalid, awready, wvalid, wready}, 4'hF);
    check("t1_payload", {awaddr, wdata, wstrb, awprot}, {3'd0, 32'h1234_5678, 4'hF, 3'b000});
    check("t1_bready_early", bready, 0);
    tick();
    check("t1_valids_drop", {awvalid, wvalid, bready}, 3'b001);
    tick();
    check("t1_rsp_valid", rsp_valid, 1);
    wait_idle();

    // wready delayed 3 cycles after awready: wvalid held with stable data
    w_delay = 3;
    send_cmd(1'b1, 3'd4, 32'h0000_00A5, 4'hF, 2'b00, '0);
    check("t2_first", {awvalid, awready, wvalid, wready}, 4'b1110);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("t2_w_held", {awvalid, wvalid, wready, wdata, wstrb}, {3'b010, 32'h0000_00A5, 4'hF});
    end
    tick();
    check("t2_w_hs", {wvalid, wready, wdata}, {2'b11, 32'h0000_00A5});
    tick();
    check("t2_w_drop", wvalid, 0);
    wait_idle();
    w_delay = 0;

    // read back both registers
    send_cmd(1'b0, 3'd4, '0, '0, 2'b00, 32'h0000_00A5);
    check("t3_ar", {arvalid, araddr, arprot}, {1'b1, 3'd4, 3'b000});
    wait_idle();
    send_cmd(1'b0, 3'd0, '0, '0, 2'b00, 32'h1234_5678);
    wait_idle();

    // error responses passed through, no retry; partial strobes merge
    bresp_cfg = 2'b10;
    send_cmd(1'b1, 3'd0, 32'hDEAD_BEEF, 4'b0011, 2'b10, '0);
    wait_idle();
    bresp_cfg = 2'b00; rresp_cfg = 2'b11;
    send_cmd(1'b0, 3'd0, '0, '0, 2'b11, 32'h1234_BEEF);
    wait_idle();
    rresp_cfg = 2'b00;
    send_cmd(1'b0, 3'd4, '0, '0, 2'b00, 32'h0000_00A5);
    wait_idle();

    // response back-pressure: outputs stable, commands ignored
    rsp_ready = 1'b0;
    send_cmd(1'b0, 3'd0, '0, '0, 2'b00, 32'h1234_BEEF);
    for (int i = 0; i < 5 && !rsp_valid; i++) tick();
    for (int i = 0; i < 10; i++) begin
      check("t5_hold", {rsp_valid, rsp_write, rsp_resp, rsp_rdata, cmd_ready},
            {1'b1, 1'b0, 2'b00, 32'h1234_BEEF, 1'b0});
      check("t5_no_req", {awvalid, wvalid, arvalid}, 0);
      cmd_valid = i[0]; cmd_write = 1'b1; cmd_addr = 3'd4; cmd_wdata = 32'hFFFF_FFFF; cmd_wstrb = 4'hF;
      tick();
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    wait_idle();

    // reset while AW and W are stalled
    aw_delay = 100; w_delay = 100;
    send_cmd(1'b1, 3'd4, 32'h1111_1111, 4'hF, 2'b00, '0);
    tick();
    check("t6_stalled", {awvalid, wvalid}, 2'b11);
    nrst = 1'b0;
    #1;
    check("t6_rst_now", {awvalid, wvalid, rsp_valid, cmd_ready, bready}, 0);
    exp_q.delete();
    aw_delay = 0; w_delay = 0;
    tick();
    nrst = 1'b1;
    tick();
    check("t6_cmd_ready", cmd_ready, 1);
    send_cmd(1'b1, 3'd4, 32'h0000_005A, 4'hF, 2'b00, '0);
    wait_idle();
    send_cmd(1'b0, 3'd4, '0, '0, 2'b00, 32'h0000_005A);
    wait_idle();

    tick(); tick();
    check("rsp_total", 64'(rsp_count), 10);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
